// File: rtl/video_source_if.sv
// Control and stream signals of the video_source raster generator.
// master = the generator itself, slave = whoever drives Start/config and consumes the stream.
interface video_source_if;
  logic       Start;
  logic       Continuous;
  logic [7:0] Width;
  logic [7:0] Height;
  logic [1:0] Pattern;
  logic [7:0] Colour;
  logic [7:0] PixelOut;
  logic       FrameOut;
  logic       LineOut;
  logic       Busy;

  modport master (
    input  Start, Continuous, Width, Height, Pattern, Colour,
    output PixelOut, FrameOut, LineOut, Busy
  );

  modport slave (
    output Start, Continuous, Width, Height, Pattern, Colour,
    input  PixelOut, FrameOut, LineOut, Busy
  );
endinterface

// File: rtl/video_source.sv
// Framed Width x Height raster source with fixed H/V blanking and a pattern generator.
// Optional feature: define VIDEO_SOURCE_STAMP_EN to stamp a frame counter onto pixel (0,0).
module video_source #(
  parameter int HBLANK = 4,
  parameter int VBLANK = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  video_source_if.master vid
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_e;
  typedef enum logic [1:0] {PAT_SOLID, PAT_XRAMP, PAT_YRAMP, PAT_CHECKER} pattern_e;

  localparam int CNT_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HB_LAST = CW'(HBLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VBLANK - 1);

  state_e        state_q, state_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    w_q, w_d, h_q, h_d;
  pattern_e      pat_q, pat_d;
  logic [7:0]    colour_q, colour_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_end;

  logic [7:0]    pixel_q, pixel_d;
  logic          frame_q, frame_d;
  logic          line_q, line_d;
  logic          busy_q, busy_d;

`ifdef VIDEO_SOURCE_STAMP_EN
  logic [7:0]    stamp_q, stamp_d;
`endif

  // State register
  always_ff @(posedge Clk) begin
    // NOTE: all state is updated with <= so every register samples the pre-edge values.
    if (Reset) begin
      // NOTE: the latched W/H/Pattern/Colour are reset too, so nothing ever holds X.
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      pat_q    <= PAT_SOLID;
      colour_q <= '0;
      cnt_q    <= '0;
      pixel_q  <= '0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef VIDEO_SOURCE_STAMP_EN
      stamp_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      pat_q    <= pat_d;
      colour_q <= colour_d;
      cnt_q    <= cnt_d;
      pixel_q  <= pixel_d;
      frame_q  <= frame_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
`ifdef VIDEO_SOURCE_STAMP_EN
      stamp_q  <= stamp_d;
`endif
    end
  end

  // Next-state and raster counters
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    pat_d     = pat_q;
    colour_d  = colour_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vid.Start && (vid.Width != 8'd0) && (vid.Height != 8'd0)) begin
          state_d  = S_ACTIVE;
          x_d      = '0;
          y_d      = '0;
          w_d      = vid.Width;
          h_d      = vid.Height;
          pat_d    = pattern_e'(vid.Pattern);
          colour_d = vid.Colour;
        end
      end
      S_ACTIVE: begin
        if (x_q == w_q - 8'd1) begin
          cnt_d = '0;
          if (y_q != h_q - 8'd1) begin
            state_d = S_HBLANK;
            y_d     = y_q + 8'd1;
          end else begin
            state_d   = S_VBLANK;
            frame_end = 1'b1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = S_ACTIVE;
          x_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (vid.Continuous) begin
            // New frame keeps W/H but picks up the current Pattern and Colour.
            state_d  = S_ACTIVE;
            x_d      = '0;
            y_d      = '0;
            pat_d    = pattern_e'(vid.Pattern);
            colour_d = vid.Colour;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VIDEO_SOURCE_STAMP_EN
  assign stamp_d = frame_end ? stamp_q + 8'd1 : stamp_q;
`endif

  // Outputs are computed from the next state so the registered outputs line up with it.
  always_comb begin
    line_d  = (state_d == S_ACTIVE);
    frame_d = line_d || (state_d == S_HBLANK);
    busy_d  = (state_d != S_IDLE);
    pixel_d = 8'h00;
    if (line_d) begin
      case (pat_d)
        PAT_SOLID: pixel_d = colour_d;
        PAT_XRAMP: pixel_d = x_d;
        PAT_YRAMP: pixel_d = y_d;
        default:   pixel_d = (x_d[0] ^ y_d[0]) ? 8'hFF : 8'h00;
      endcase
`ifdef VIDEO_SOURCE_STAMP_EN
      if ((x_d == 8'd0) && (y_d == 8'd0)) pixel_d = stamp_q;
`endif
    end
  end

`ifndef VIDEO_SOURCE_STAMP_EN
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

  assign vid.PixelOut = pixel_q;
  assign vid.FrameOut = frame_q;
  assign vid.LineOut  = line_q;
  assign vid.Busy     = busy_q;

endmodule
